alu_word_sequencer: RTL

Multi-word operand sequencer that sits directly upstream of the `ALU` datapath and also consumes its results. It accepts one wide operation (`WORDS*BITS`-bit operands) per valid/ready handshake. It then feeds the `BITS`-wide ALU one word per cycle, least-significant word first, chaining the ALU carry between words. It assembles the wide result, final carry and error flag for a downstream consumer.

---
 rtl/alu_word_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer
// Feeds a BITS-wide combinational ALU one word per cycle (LSW first),
// chaining the ALU carry between words, and assembles the WORDS*BITS
// wide result, final carry and error summary for a downstream consumer.
// Optional feature macro: ALU_SEQ_ERR_ABORT_EN -- when defined, the first
// word that raises the ALU error ends the operation early.
module alu_word_sequencer #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WORDS*BITS-1:0]  i_a,
  input  logic [WORDS*BITS-1:0]  i_b,
  input  logic [1:0]             i_op,
  input  logic                   i_carry,
  output logic [BITS-1:0]        o_alu_a,
  output logic [BITS-1:0]        o_alu_b,
  output logic [1:0]             o_alu_op,
  output logic                   o_alu_carry,
  input  logic [BITS-1:0]        i_alu_out,
  input  logic                   i_alu_carry,
  input  logic                   i_alu_ERR,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WORDS*BITS-1:0]  o_result,
  output logic                   o_carry,
  output logic                   o_err
);

  localparam int W     = WORDS * BITS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_err;
  logic [BITS-1:0]  r_result_word [WORDS];

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic [BITS-1:0]  w_a_word [WORDS];
  logic [BITS-1:0]  w_b_word [WORDS];

  assign w_run    = (r_state == S_RUN);
  assign o_ready  = (r_state == S_IDLE) && i_rst_n;
  assign w_accept = i_valid && o_ready;
  assign w_last   = (r_idx == LAST_IDX);
  assign o_valid  = (r_state == S_DONE);

  // Split the latched operands into words and stitch result words together
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign w_a_word[gi] = r_a[gi*BITS +: BITS];
      assign w_b_word[gi] = r_b[gi*BITS +: BITS];
      assign o_result[gi*BITS +: BITS] = r_result_word[gi];

      // Result word: cleared on acceptance, captured when its index is active
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_result_word[gi] <= '0;
        end else if (w_accept) begin
          r_result_word[gi] <= '0;
        end else if (w_run && (r_idx == IDX_W'(gi))) begin
          r_result_word[gi] <= i_alu_out;
        end
      end
    end
  endgenerate

  // ALU operand drive: only the active word during RUN, zeros otherwise
  always_comb begin
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_carry = 1'b0;
    if (w_run) begin
      o_alu_a     = w_a_word[r_idx];
      o_alu_b     = w_b_word[r_idx];
      o_alu_carry = r_carry;
    end
  end

  assign o_alu_op = r_op;
  assign o_carry  = r_carry_out;
  assign o_err    = r_err;

  // Sequencer FSM: accept, walk the words chaining carry, then hold result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a         <= i_a;
            r_b         <= i_b;
            r_op        <= i_op;
            r_carry     <= i_carry;
            r_carry_out <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= i_alu_carry;
          r_err   <= r_err | i_alu_ERR;
          r_idx   <= r_idx + IDX_W'(1);
`ifdef ALU_SEQ_ERR_ABORT_EN
          // An erroring word ends the operation; higher words stay cleared
          if (w_last || i_alu_ERR) begin
            r_carry_out <= i_alu_carry;
            r_state     <= S_DONE;
          end
`else
          if (w_last) begin
            r_carry_out <= i_alu_carry;
            r_state     <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          if (i_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
